lut_piksel_esleme: RTL

Downstream stage of the histogram-equalization pipeline.
- Receives the 256-entry equalized-histogram mapping (20-bit signed values) over a write port and stores it in a local LUT.
- Remaps a streamed 8-bit grayscale frame of FRAME_PIX pixels through that LUT, one pixel per cycle.
- Emits the equalized frame on a valid/ready output stream with end-of-frame marking.

---
 rtl/hist_pkg.sv | 17 +
 rtl/lut_piksel_esleme_if.sv | 25 ++
 rtl/lut_piksel_esleme_lut_bellek.sv | 33 +++
 rtl/lut_piksel_esleme.sv | 134 +++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared constants and types for the histogram-equalization pipeline.
package hist_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned HIST_BINS = 256;
    localparam int unsigned FRAME_PIX = 76800;
    localparam int unsigned CNT_W     = 17;
    // Width of the signed equalized-histogram mapping values.
    localparam int unsigned EQ_W      = 20;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

endpackage

// File: rtl/lut_piksel_esleme_if.sv
// Pixel stream bundle: input stream (s_*) and remapped output stream (m_*).
interface lut_piksel_esleme_if;
    import hist_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_last;

    // Environment side: sources input pixels, sinks remapped pixels.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    // Remapper side.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/lut_piksel_esleme_lut_bellek.sv
// 256x8 LUT RAM: synchronous write, synchronous read with read enable, no reset.
module lut_bellek
    import hist_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [PIX_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [PIX_W-1:0] i_rd_addr,
    output logic [PIX_W-1:0] o_rd_data
);

    logic [PIX_W-1:0] r_mem [HIST_BINS];
    logic [PIX_W-1:0] r_rd_data;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port; output holds while the read enable is low.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lut_piksel_esleme.sv
// LUT pixel remapper: loads a 256-entry mapping in IDLE, then streams one frame
// through it with a two-stage pipeline (LUT read, output register).
// Optional macro LUT_SAT_EN: clamp written values to 0..255 instead of truncating.
module lut_piksel_esleme #(
    parameter int unsigned PIX_W     = hist_pkg::PIX_W,
    parameter int unsigned FRAME_PIX = hist_pkg::FRAME_PIX,
    parameter int unsigned CNT_W     = hist_pkg::CNT_W
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_lut_wr_en,
    input  logic [PIX_W-1:0]                  i_lut_wr_addr,
    input  logic signed [hist_pkg::EQ_W-1:0]  i_lut_wr_data,
    input  logic                              i_lut_load_done,
    lut_piksel_esleme_if.slave                bus,
    output logic                              o_frame_done,
    output logic                              o_busy
);

    localparam int unsigned EQ_W = hist_pkg::EQ_W;
    localparam logic [CNT_W-1:0] LP_FRAME = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(FRAME_PIX - 1);

    hist_pkg::state_e r_state, w_state_nxt;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             w_en, w_s_ready, w_s_fire, w_m_fire, w_last_in;
    logic             w_wr_en;
    logic [PIX_W-1:0] w_wr_data, w_rd_data;
    logic             r_v1, r_l1;
    logic             r_m_valid, r_m_last, r_frame_done;
    logic [PIX_W-1:0] r_m_data;

    // Handshake and pipeline enable.
    always_comb begin
        w_en      = !r_m_valid || bus.m_ready;
        w_s_ready = (r_state == hist_pkg::STREAM) && w_en && (r_pix_cnt < LP_FRAME);
        w_s_fire  = bus.s_valid && w_s_ready;
        w_m_fire  = r_m_valid && bus.m_ready;
        w_last_in = (r_pix_cnt == LP_LAST);
        w_wr_en   = i_lut_wr_en && (r_state == hist_pkg::IDLE);
    end

`ifdef LUT_SAT_EN
    // Clamp the signed mapping value into the pixel range.
    always_comb begin
        w_wr_data = i_lut_wr_data[PIX_W-1:0];
        if (i_lut_wr_data[EQ_W-1]) begin
            w_wr_data = '0;
        end else if (|i_lut_wr_data[EQ_W-2:PIX_W]) begin
            w_wr_data = '1;
        end
    end
`else
    logic [EQ_W-PIX_W-1:0] w_unused_hi;

    // Plain truncation: keep the low pixel bits only.
    always_comb begin
        w_wr_data   = i_lut_wr_data[PIX_W-1:0];
        w_unused_hi = i_lut_wr_data[EQ_W-1:PIX_W];
    end
`endif

    lut_bellek u_lut_bellek (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (i_lut_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_en),
        .i_rd_addr (bus.s_data),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= hist_pkg::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            hist_pkg::IDLE:   if (i_lut_load_done)          w_state_nxt = hist_pkg::STREAM;
            hist_pkg::STREAM: if (w_s_fire && w_last_in)    w_state_nxt = hist_pkg::DRAIN;
            hist_pkg::DRAIN:  if (w_m_fire && r_m_last)     w_state_nxt = hist_pkg::IDLE;
            default:                                        w_state_nxt = hist_pkg::IDLE;
        endcase
    end

    // Accepted-pixel counter; cleared on frame start, stops at FRAME_PIX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_cnt <= '0;
        end else if ((r_state == hist_pkg::IDLE) && i_lut_load_done) begin
            r_pix_cnt <= '0;
        end else if (w_s_fire) begin
            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
    end

    // Pipeline valid/last tracking and output register; everything holds on stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1         <= 1'b0;
            r_l1         <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_data     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_m_fire && r_m_last;
            if (w_en) begin
                r_v1      <= w_s_fire;
                r_l1      <= w_s_fire && w_last_in;
                r_m_valid <= r_v1;
                r_m_last  <= r_v1 && r_l1;
                if (r_v1) begin
                    r_m_data <= w_rd_data;
                end
            end
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_data   = r_m_data;
    assign bus.m_last   = r_m_last;
    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_state != hist_pkg::IDLE);

endmodule
